pwr_seq_ctrl: RTL

Board power sequencer state machine: brings up P1V8, P3V3 and P1V1 in order behind VCORE and releases PCIe/PHY reset and CPU POR. It handles power-good timeouts, power-good loss and orderly reverse-order shutdown. It sits beside the I2C expander in the CPLD top and consumes the existing 1 ms tick. It replaces the free-running per-rail timers with one supervised sequence.

---
 rtl/pwr_seq_ctrl_pkg.sv | 43 ++++
 rtl/pwr_seq_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pwr_seq_ctrl_pkg.sv
// Shared definitions for the board power sequencer: state encodings,
// fault codes and default delay values in milliseconds.
package pwr_seq_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_OFF     = 4'd0,
    ST_W_VCORE = 4'd1,
    ST_D_VCORE = 4'd2,
    ST_W_1V8   = 4'd3,
    ST_D_1V8   = 4'd4,
    ST_W_3V3   = 4'd5,
    ST_D_3V3   = 4'd6,
    ST_W_1V1   = 4'd7,
    ST_D_1V1   = 4'd8,
    ST_D_POR   = 4'd9,
    ST_ON      = 4'd10,
    ST_SD_1V1  = 4'd11,
    ST_SD_3V3  = 4'd12,
    ST_SD_1V8  = 4'd13,
    ST_FAULT   = 4'd14
  } state_e;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_VCORE   = 3'd1;
  localparam logic [2:0] FC_P1V8    = 3'd2;
  localparam logic [2:0] FC_P3V3    = 3'd3;
  localparam logic [2:0] FC_P1V1    = 3'd4;
  localparam logic [2:0] FC_PG_LOST = 3'd5;

  localparam int DEF_DLY_STAGE_MS  = 6;
  localparam int DEF_DLY_P1V1_MS   = 10;
  localparam int DEF_DLY_POR_MS    = 400;
  localparam int DEF_PG_TIMEOUT_MS = 50;
  localparam int DEF_OFF_DLY_MS    = 10;
  localparam int DEF_CNT_W         = 11;

  // The encoding is ordered along the sequence, so output and monitor
  // windows are simple contiguous ranges.
  function automatic logic st_between(input state_e s, input state_e lo, input state_e hi);
    return (s >= lo) && (s <= hi);
  endfunction

endpackage

// File: rtl/pwr_seq_ctrl.sv
// Board power sequencer: VCORE -> P1V8 -> P3V3 -> P1V1 bring-up, reset
// release, power-good supervision and reverse-order shutdown on one ms counter.
module pwr_seq_ctrl
  import pwr_seq_ctrl_pkg::*;
#(
  parameter int DLY_STAGE_MS  = DEF_DLY_STAGE_MS,
  parameter int DLY_P1V1_MS   = DEF_DLY_P1V1_MS,
  parameter int DLY_POR_MS    = DEF_DLY_POR_MS,
  parameter int PG_TIMEOUT_MS = DEF_PG_TIMEOUT_MS,
  parameter int OFF_DLY_MS    = DEF_OFF_DLY_MS,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       ms_tick,
  input  logic       vcore_en,
  input  logic       vcore_pwrgd,
  input  logic       p1v8_pwrgd,
  input  logic       p3v3_pwrgd,
  input  logic       p1v1_pwrgd,
  input  logic       fault_clr,
  output logic       p1v8_en,
  output logic       p3v3_en,
  output logic       p1v1_en,
  output logic       pcie_rst_n,
  output logic       phy_rst_n,
  output logic       cpu_por_n,
  output logic       seq_done,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [3:0] state
);

  // A delay of N expires on the tick seen while the counter holds N-1.
  localparam logic [CNT_W-1:0] T_STAGE = CNT_W'(DLY_STAGE_MS - 1);
  localparam logic [CNT_W-1:0] T_P1V1  = CNT_W'(DLY_P1V1_MS - 1);
  localparam logic [CNT_W-1:0] T_POR   = CNT_W'(DLY_POR_MS - DLY_P1V1_MS - 1);
  localparam logic [CNT_W-1:0] T_PGTO  = CNT_W'(PG_TIMEOUT_MS - 1);
  localparam logic [CNT_W-1:0] T_OFF   = CNT_W'(OFF_DLY_MS - 1);

  state_e           state_q, state_d, sd_target;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       fault_code_q, fault_code_d;
  logic             p1v8_en_q, p3v3_en_q, p1v1_en_q, rst_rel_q, por_rel_q, done_q, fault_q;
  logic             hit_stage, hit_p1v1, hit_por, hit_pgto, hit_off, pg_lost;

  assign hit_stage = ms_tick && (cnt_q == T_STAGE);
  assign hit_p1v1  = ms_tick && (cnt_q == T_P1V1);
  assign hit_por   = ms_tick && (cnt_q == T_POR);
  assign hit_pgto  = ms_tick && (cnt_q == T_PGTO);
  assign hit_off   = ms_tick && (cnt_q == T_OFF);

  // A rail is supervised from its settle state through ON.
  assign pg_lost = (st_between(state_q, ST_D_VCORE, ST_ON) && !vcore_pwrgd)
                || (st_between(state_q, ST_D_1V8,   ST_ON) && !p1v8_pwrgd)
                || (st_between(state_q, ST_D_3V3,   ST_ON) && !p3v3_pwrgd)
                || (st_between(state_q, ST_D_1V1,   ST_ON) && !p1v1_pwrgd);

  // Shutdown starts at the highest rail already enabled; none enabled means OFF.
  always_comb begin
    sd_target = ST_OFF;
    if (state_q >= ST_W_1V1)      sd_target = ST_SD_1V1;
    else if (state_q >= ST_W_3V3) sd_target = ST_SD_3V3;
    else if (state_q >= ST_W_1V8) sd_target = ST_SD_1V8;
  end

  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_OFF:    if (vcore_en) state_d = ST_W_VCORE;
      ST_SD_1V1: if (hit_off) state_d = ST_SD_3V3;
      ST_SD_3V3: if (hit_off) state_d = ST_SD_1V8;
      ST_SD_1V8: if (hit_off) state_d = ST_OFF;
      ST_FAULT:  if (fault_clr && !vcore_en) state_d = ST_OFF;
      default: begin
        if (pg_lost) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_PG_LOST;
        end else if (!vcore_en) begin
          state_d = sd_target;
        end else begin
          case (state_q)
            ST_W_VCORE:
              if (vcore_pwrgd) state_d = ST_D_VCORE;
              else if (hit_pgto) begin state_d = ST_FAULT; fault_code_d = FC_VCORE; end
            ST_D_VCORE: if (hit_stage) state_d = ST_W_1V8;
            ST_W_1V8:
              if (p1v8_pwrgd) state_d = ST_D_1V8;
              else if (hit_pgto) begin state_d = ST_FAULT; fault_code_d = FC_P1V8; end
            ST_D_1V8: if (hit_stage) state_d = ST_W_3V3;
            ST_W_3V3:
              if (p3v3_pwrgd) state_d = ST_D_3V3;
              else if (hit_pgto) begin state_d = ST_FAULT; fault_code_d = FC_P3V3; end
            ST_D_3V3: if (hit_stage) state_d = ST_W_1V1;
            ST_W_1V1:
              if (p1v1_pwrgd) state_d = ST_D_1V1;
              else if (hit_pgto) begin state_d = ST_FAULT; fault_code_d = FC_P1V1; end
            ST_D_1V1: if (hit_p1v1) state_d = ST_D_POR;
            ST_D_POR: if (hit_por) state_d = ST_ON;
            default: ;
          endcase
        end
      end
    endcase
    if (state_d != ST_FAULT) fault_code_d = FC_NONE;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (ms_tick)       cnt_d = cnt_q + CNT_W'(1);
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      fault_code_q <= FC_NONE;
      p1v8_en_q    <= 1'b0;
      p3v3_en_q    <= 1'b0;
      p1v1_en_q    <= 1'b0;
      rst_rel_q    <= 1'b0;
      por_rel_q    <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_code_q <= fault_code_d;
      p1v8_en_q    <= st_between(state_d, ST_W_1V8, ST_SD_1V8);
      p3v3_en_q    <= st_between(state_d, ST_W_3V3, ST_SD_3V3);
      p1v1_en_q    <= st_between(state_d, ST_W_1V1, ST_SD_1V1);
      rst_rel_q    <= st_between(state_d, ST_D_POR, ST_ON);
      por_rel_q    <= (state_d == ST_ON);
      done_q       <= (state_d == ST_ON);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign p1v8_en    = p1v8_en_q;
  assign p3v3_en    = p3v3_en_q;
  assign p1v1_en    = p1v1_en_q;
  assign pcie_rst_n = rst_rel_q;
  assign phy_rst_n  = rst_rel_q;
  assign cpu_por_n  = por_rel_q;
  assign seq_done   = done_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign state      = state_q;

endmodule
